// File: rtl/axi_lite_loop_top.sv
// AXI4-Lite loop: a self-starting AXI-Lite master repeatedly runs single-beat
// transactions against an AXI-Lite slave backed by a small register memory.
// The slave memory resets to mem[k] = k; out-of-range addresses answer DECERR.

// ---------------------------------------------------------------------------
// Master: one transaction per pass through IDLE, direction chosen by i_wr.
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic [ADDR_W-1:0] i_addrin,
    input  logic              i_wr,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_resp,
    // Write address channel
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    // Write data channel
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    // Write response channel
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    // Read address channel
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    // Read data channel
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrAddr,
        StWrResp
    } state_t;

    state_t state;

    logic aw_ok;
    logic w_ok;

    // A write channel is finished once its valid has dropped or is being accepted now.
    always_comb begin
        aw_ok = !m_axi_awvalid || m_axi_awready;
        w_ok  = !m_axi_wvalid || m_axi_wready;
    end

    // Master FSM with all AXI outputs registered.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= StIdle;
            o_rdata       <= '0;
            o_resp        <= 2'b00;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // Address and direction are only sampled here.
                    if (i_wr) begin
                        m_axi_awaddr  <= i_addrin;
                        m_axi_wdata   <= DATA_W'(i_addrin) << 1;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= StWrAddr;
                    end else begin
                        m_axi_araddr  <= i_addrin;
                        m_axi_arvalid <= 1'b1;
                        state         <= StRdAddr;
                    end
                end
                StRdAddr: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= StRdData;
                    end
                end
                StRdData: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        o_rdata      <= m_axi_rdata;
                        o_resp       <= m_axi_rresp;
                        m_axi_rready <= 1'b0;
                        state        <= StIdle;
                    end
                end
                StWrAddr: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        m_axi_bready <= 1'b1;
                        state        <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        o_resp       <= m_axi_bresp;
                        m_axi_bready <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Slave: registered ready pulses, DEPTH-word memory, DECERR above DEPTH-1.
// ---------------------------------------------------------------------------
module axi_lite_slave #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] aw_addr_q;
    logic              aw_done;
    logic [DATA_W-1:0] w_data_q;
    logic              w_done;

    logic rd_hit;
    logic wr_hit;

    // Address decode for both directions.
    always_comb begin
        rd_hit = s_axi_araddr < ADDR_W'(DEPTH);
        wr_hit = aw_addr_q < ADDR_W'(DEPTH);
    end

    // Read channel: one-cycle arready pulse, rvalid held until rready.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RespOkay;
        end else begin
            s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                if (rd_hit) begin
                    s_axi_rdata <= mem[s_axi_araddr[IdxW-1:0]];
                    s_axi_rresp <= RespOkay;
                end else begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RespDecerr;
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Write channel: independent aw/w acceptance, commit once both are held.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RespOkay;
            aw_addr_q     <= '0;
            aw_done       <= 1'b0;
            w_data_q      <= '0;
            w_done        <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= DATA_W'(k);
            end
        end else begin
            // No new acceptance while a response is still outstanding.
            s_axi_awready <= s_axi_awvalid && !s_axi_awready && !aw_done && !s_axi_bvalid;
            s_axi_wready  <= s_axi_wvalid && !s_axi_wready && !w_done && !s_axi_bvalid;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_addr_q <= s_axi_awaddr;
                aw_done   <= 1'b1;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_data_q <= s_axi_wdata;
                w_done   <= 1'b1;
            end
            if (aw_done && w_done) begin
                aw_done      <= 1'b0;
                w_done       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                if (wr_hit) begin
                    mem[aw_addr_q[IdxW-1:0]] <= w_data_q;
                    s_axi_bresp              <= RespOkay;
                end else begin
                    s_axi_bresp <= RespDecerr;
                end
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Top: master mdut wired point-to-point to the slave.
// ---------------------------------------------------------------------------
module axi_lite_loop_top #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic [ADDR_W-1:0] i_addrin,
    input  logic              i_wr,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_resp
);

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    axi_lite_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) mdut (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_aresetn(m_axi_aresetn),
        .i_addrin     (i_addrin),
        .i_wr         (i_wr),
        .o_rdata      (o_rdata),
        .o_resp       (o_resp),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_awaddr (awaddr),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_wdata  (wdata),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_bresp  (bresp),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_araddr (araddr),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp)
    );

    axi_lite_slave #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) sdut (
        .s_axi_aclk   (m_axi_aclk),
        .s_axi_aresetn(m_axi_aresetn),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_awaddr (awaddr),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_wdata  (wdata),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_bresp  (bresp),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp)
    );

endmodule

// File: tb/tb_axi_lite_loop_top.sv
// Directed bench for axi_lite_loop_top: reads, writes, DECERR and mid-read reset.
module tb_axi_lite_loop_top;

    logic        clk;
    logic        aresetn;
    logic [31:0] addrin;
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;

    int errors = 0;
    int checks = 0;

    axi_lite_loop_top dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(aresetn),
        .i_addrin     (addrin),
        .i_wr         (wr),
        .o_rdata      (rdata),
        .o_resp       (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All AXI valid/ready lines inside the loop.
    function automatic logic [31:0] handshake_bits();
        return {24'd0,
                dut.mdut.m_axi_awvalid, dut.mdut.m_axi_awready,
                dut.mdut.m_axi_wvalid,  dut.mdut.m_axi_wready,
                dut.mdut.m_axi_bvalid | dut.mdut.m_axi_bready,
                dut.mdut.m_axi_arvalid, dut.mdut.m_axi_arready,
                dut.mdut.m_axi_rvalid | dut.mdut.m_axi_rready};
    endfunction

    // Present one transaction and wait (bounded) for its final handshake,
    // returning #1 after the completing clock edge.
    task automatic run(input string tag, input logic w, input logic [31:0] a);
        logic done;
        wr     = w;
        addrin = a;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (w) done = dut.mdut.m_axi_bvalid && dut.mdut.m_axi_bready;
            else   done = dut.mdut.m_axi_rvalid && dut.mdut.m_axi_rready;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd_addrs [10];
    logic        seen;

    initial begin
        rd_addrs = '{32'd7, 32'd0, 32'd15, 32'd1, 32'd12, 32'd9, 32'd4, 32'd14, 32'd2, 32'd11};

        aresetn = 1'b0;
        wr      = 1'b0;
        addrin  = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {30'd0, resp}, 32'd0);
        check("rst_hs", handshake_bits(), 32'd0);

        @(negedge clk);
        aresetn = 1'b1;
        run("rd3", 1'b0, 32'd3);
        check("rd3_rdata", rdata, 32'd3);
        check("rd3_resp", {30'd0, resp}, 32'd0);
        check("rd3_rready_low", {31'd0, dut.mdut.m_axi_rready}, 32'd0);

        // Back-to-back reads of the reset pattern mem[k] = k.
        for (int i = 0; i < 10; i++) begin
            run($sformatf("rd%0d", i), 1'b0, rd_addrs[i]);
            check($sformatf("b2b%0d_rdata", i), rdata, rd_addrs[i]);
            check($sformatf("b2b%0d_resp", i), {30'd0, resp}, 32'd0);
            check($sformatf("b2b%0d_rready_low", i), {31'd0, dut.mdut.m_axi_rready}, 32'd0);
        end

        // Write stores address*2; o_rdata keeps the previous read (11).
        run("wr5", 1'b1, 32'd5);
        check("wr5_resp", {30'd0, resp}, 32'd0);
        check("wr5_rdata_kept", rdata, 32'd11);
        run("rd5", 1'b0, 32'd5);
        check("rd5_rdata", rdata, 32'd10);
        check("rd5_resp", {30'd0, resp}, 32'd0);

        // Out-of-range accesses.
        run("rd20", 1'b0, 32'd20);
        check("rd20_rdata", rdata, 32'd0);
        check("rd20_resp", {30'd0, resp}, 32'd3);
        run("wr20", 1'b1, 32'd20);
        check("wr20_resp", {30'd0, resp}, 32'd3);
        run("rd0", 1'b0, 32'd0);
        check("rd0_rdata", rdata, 32'd0);
        check("rd0_resp", {30'd0, resp}, 32'd0);
        // Word 4 shares low bits with 20 and must be untouched.
        run("rd4", 1'b0, 32'd4);
        check("rd4_rdata", rdata, 32'd4);
        run("rd9", 1'b0, 32'd9);
        check("rd9_rdata", rdata, 32'd9);

        // Reset while the read of 12 sits in RD_DATA.
        addrin = 32'd12;
        wr     = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = dut.mdut.m_axi_rready;
        end
        check("mid_rdata_phase", {31'd0, seen}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_hs", handshake_bits(), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_resp", {30'd0, resp}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        addrin  = 32'd5;
        aresetn = 1'b1;
        // Memory is back to its reset pattern, so word 5 reads 5 again.
        run("post_rst_rd5", 1'b0, 32'd5);
        check("post_rst_rd5_rdata", rdata, 32'd5);
        check("post_rst_rd5_resp", {30'd0, resp}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
